sp1_m: RTL
==========

Name: sp1_m

Overview:
SPI master that pairs with the existing sp1_s slave. It serialises one 8-bit word onto mosi while capturing one 8-bit word from miso, and generates sp_clk and ss from the system clock.
- Used in the same top level as sp1_s so both ends of the link are ours.
- The bus format matches sp1_s exactly:
  - CPOL=0.
  - mosi is launched on the sp_clk rising edge and sampled by the slave on the falling edge.
  - miso is launched by the slave on the rising edge and sampled by the master on the falling edge.
  - mosi is MSB-first; miso is LSB-first.

Parameters:
- CLK_DIV, 2, clk cycles per sp_clk half-period (>=1).
- DATA_W, 8, word width (fixed at 8 for sp1_s compatibility).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a transfer; honoured only when busy_m=0.
- data_send  in  8  word to transmit; captured in the cycle start is accepted.
- miso  in  1  serial data from slave.
- sp_clk  out  1  SPI clock, registered, idle low.
- mosi  out  1  serial data to slave, registered.
- ss  out  1  slave select, active low, registered.
- busy_m  out  1  high from the cycle after start is accepted until the cycle done pulses.
- done  out  1  one-cycle pulse when m_rece is valid.
- m_rece  out  8  last received word; held until the next done.

Behaviour:
- Reset (async, rst=1): ss=1, sp_clk=0, mosi=0, busy_m=0, done=0, m_rece=0, state=IDLE, counters=0.
- States:
  - IDLE: ss=1, sp_clk=0.
    - start=1 -> next edge: load tx_sh=data_send, ss=0, mosi=data_send[7], busy_m=1, bit=0, div=0 -> SETUP.
  - SETUP: wait CLK_DIV cycles (ss low, sp_clk low) -> set sp_clk=1 -> HIGH.
  - HIGH:
    - On entry edge (sp_clk 0->1), if bit>0 then mosi=tx_sh[7-bit].
    - After CLK_DIV cycles: sp_clk=0 and rx_sh[bit]=miso (sample taken in the same clk edge that drives sp_clk low) -> LOW.
  - LOW: after CLK_DIV cycles:
    - bit<7: bit++, sp_clk=1 -> HIGH.
    - bit==7: -> HOLD.
  - HOLD: wait CLK_DIV cycles -> ss=1, m_rece=rx_sh, done=1, busy_m=0, mosi=0 -> IDLE.
- Timing:
  - Exactly 8 rising and 8 falling sp_clk edges per transfer.
  - ss low for 18*CLK_DIV clk cycles; 36 cycles at default.
  - done asserts on the same edge ss returns high.
- start while busy_m=1: ignored; data_send is not re-sampled.
- start in the done cycle: accepted (state is IDLE); this gives back-to-back transfers with ss high for exactly 1 cycle.
- rst mid-transfer: immediate abort to reset values, with no done pulse; m_rece=0.
- CLK_DIV=1: same sequence, with sp_clk period 2 clk cycles.
- Divider counter width = $clog2(CLK_DIV+1). Bit counter is 3 bits; no wrap past 7.

Decomposition:
- Package sp1_pkg:
  - state enum {IDLE, SETUP, HIGH, LOW, HOLD}.
  - SP1_DATA_W=8.
  - Bit-order constants: MOSI_MSB_FIRST=1, MISO_LSB_FIRST=1.
  - Default CLK_DIV.
- One natural sub-module, sp1_tick: a half-period counter with a single-cycle tick output, restart input, and parameter CLK_DIV. The FSM and shift registers stay in sp1_m.

Test Plan:
- Reset: assert rst for 3 cycles, with start=1 held -> ss=1, sp_clk=0, mosi=0, busy_m=0, done=0, m_rece=0 throughout; no transfer starts.
- Single transfer, CLK_DIV=2, data_send=0xA5, slave model returning 0x3C LSB-first on miso:
  - mosi at each sp_clk falling edge = 1,0,1,0,0,1,0,1.
  - m_rece=0x3C at done.
  - ss low for exactly 36 cycles; 8 rising sp_clk edges.
- Loopback against an sp1_s instance:
  - Master sends 0x5A, slave data_send=0xC3.
  - After done: m_rece=0xC3 and sp1_s s_rece=0x5A.
- start pulsed at cycle 10 of an active 0x11 transfer with data_send=0xFF -> mosi stream still 0x11; single done; busy_m stays 1 until then.
- Back-to-back: start held high, data_send 0x01 then 0x80 -> two done pulses 37 cycles apart; ss high exactly 1 cycle between frames.
- rst pulse after the 3rd falling sp_clk edge -> outputs return to reset values asynchronously; no done. A following start with 0xF0 completes normally with CLK_DIV=1 timing (ss low 18 cycles when CLK_DIV=1).

Source files
------------

// File: rtl/sp1_pkg.sv
// Shared types and constants for the sp1 SPI link (master side).
// No logic here; states, widths and bit-order selection only.
// Backpressure: not applicable.
package sp1_pkg;

    localparam int SP1_DATA_W      = 8;
    localparam int SP1_BIT_W       = 3;
    localparam int SP1_CLK_DIV_DEF = 2;

    // Must stay in line with sp1_s: mosi MSB-first, miso LSB-first.
    localparam bit MOSI_MSB_FIRST = 1'b1;
    localparam bit MISO_LSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD
    } sp1_state_t;

    // Receive-register slot for the bit currently being sampled.
    function automatic logic [SP1_BIT_W-1:0] rx_bit_pos(input logic [SP1_BIT_W-1:0] b);
        logic [SP1_BIT_W-1:0] top;
        top = SP1_BIT_W'(SP1_DATA_W - 1);
        return MISO_LSB_FIRST ? b : (top - b);
    endfunction

endpackage

// File: rtl/sp1_tick.sv
// Half-period timer: tick is high in the last clk cycle of each CLK_DIV-cycle window.
// Latency: first tick CLK_DIV-1 cycles after restart drops; free-runs while restart is low.
// Backpressure: none; restart holds the count at zero.
module sp1_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST) && !restart;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sp1_m.sv
// SPI master (CPOL=0) for sp1_s: one 8-bit exchange per accepted start, mosi MSB-first, miso LSB-first.
// Latency: ss low for 18*CLK_DIV cycles; done on the edge ss returns high, m_rece valid with it.
// Backpressure: start is ignored while busy_m=1; a start in the done cycle is accepted.
module sp1_m
    import sp1_pkg::*;
#(
    parameter int CLK_DIV = SP1_CLK_DIV_DEF,
    parameter int DATA_W  = SP1_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_send,
    input  logic              miso,
    output logic              sp_clk,
    output logic              mosi,
    output logic              ss,
    output logic              busy_m,
    output logic              done,
    output logic [DATA_W-1:0] m_rece
);

    localparam logic [SP1_BIT_W-1:0] LAST_BIT = SP1_BIT_W'(DATA_W - 1);

    sp1_state_t           state, state_nxt;
    logic                 tick;
    logic [DATA_W-1:0]    tx_sh;
    logic [DATA_W-1:0]    rx_sh;
    logic [SP1_BIT_W-1:0] bit_cnt;

    // Timer is parked while idle so every transfer starts from a clean half-period.
    sp1_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (state == IDLE),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   if (tick)  state_nxt = HIGH;
            HIGH:    if (tick)  state_nxt = LOW;
            LOW:     if (tick)  state_nxt = (bit_cnt == LAST_BIT) ? HOLD : HIGH;
            HOLD:    if (tick)  state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss      <= 1'b1;
            sp_clk  <= 1'b0;
            mosi    <= 1'b0;
            busy_m  <= 1'b0;
            done    <= 1'b0;
            m_rece  <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sh   <= data_send;
                        rx_sh   <= '0;
                        ss      <= 1'b0;
                        mosi    <= MOSI_MSB_FIRST ? data_send[DATA_W-1] : data_send[0];
                        busy_m  <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (tick) sp_clk <= 1'b1;
                end
                HIGH: begin
                    // Sample on the same edge that drops sp_clk.
                    if (tick) begin
                        sp_clk                  <= 1'b0;
                        rx_sh[rx_bit_pos(bit_cnt)] <= miso;
                    end
                end
                LOW: begin
                    if (tick && (bit_cnt != LAST_BIT)) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        sp_clk  <= 1'b1;
                        if (MOSI_MSB_FIRST) begin
                            tx_sh <= tx_sh << 1;
                            mosi  <= tx_sh[DATA_W-2];
                        end else begin
                            tx_sh <= tx_sh >> 1;
                            mosi  <= tx_sh[1];
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        ss     <= 1'b1;
                        m_rece <= rx_sh;
                        done   <= 1'b1;
                        busy_m <= 1'b0;
                        mosi   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
